// File: rtl/pipelined_muldiv_unit_if.sv
// Issue/result bundle between the EXE stage and the multiply/divide unit.
// master = CPU side, slave = the muldiv unit.
interface pipelined_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            cancel;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/pipelined_muldiv_unit.sv
// Multiply/divide unit with HI/LO: fixed-latency multiply, restoring divider.
// Optional macro MULDIV_EARLY_OUT_EN: divides with |a| < |b| skip the iterations.
module pipelined_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input logic                   clk,
    input logic                   clr,
    pipelined_muldiv_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int CMAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
    localparam int CW   = $clog2(CMAX + 1);

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] hi_q, lo_q, a_q, b_q, quo_q, rem_q;
    logic            done_q, mul_signed_q, neg_quo_q, neg_rem_q, zero_div_q;

    logic            accept, div_signed, early;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [2*XLEN-1:0] product;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff, quo_fix, rem_fix;
    logic            q_bit;

    assign accept     = (state == S_IDLE) && bus.start && !bus.cancel;
    assign div_signed = (bus.op == OP_DIV);
    assign mag_a      = (div_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
    assign mag_b      = (div_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;

`ifdef MULDIV_EARLY_OUT_EN
    assign early = (bus.op == OP_DIV || bus.op == OP_DIVU) && (bus.b != '0) && (mag_a < mag_b);
`else
    assign early = 1'b0;
`endif

    // Sign-extending to 2*XLEN makes one modular multiply serve both MULT and MULTU.
    assign product = {{XLEN{mul_signed_q & a_q[XLEN-1]}}, a_q} *
                     {{XLEN{mul_signed_q & b_q[XLEN-1]}}, b_q};

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign q_bit   = (shifted >= {1'b0, b_q});
    assign diff    = XLEN'(shifted - {1'b0, b_q});
    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    // During a divide b_q holds the divisor magnitude and quo_q shifts the dividend out
    // while quotient bits shift in; a_q keeps the raw dividend for the b=0 result.
    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= S_IDLE;
            count        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            done_q       <= 1'b0;
            mul_signed_q <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            zero_div_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                a_q          <= bus.a;
                                b_q          <= bus.b;
                                mul_signed_q <= (bus.op == OP_MULT);
                                count        <= CW'(MUL_STAGES - 1);
                                state        <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_q        <= bus.a;
                                b_q        <= mag_b;
                                neg_quo_q  <= div_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                                neg_rem_q  <= div_signed & bus.a[XLEN-1];
                                zero_div_q <= (bus.b == '0);
                                count      <= CW'(XLEN - 1);
                                if (early) begin
                                    quo_q <= '0;
                                    rem_q <= mag_a;
                                    state <= S_FIX;
                                end else begin
                                    quo_q <= mag_a;
                                    rem_q <= '0;
                                    state <= S_DIV;
                                end
                            end
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (bus.cancel) begin
                        state <= S_IDLE;
                    end else if (count == '0) begin
                        {hi_q, lo_q} <= product;
                        done_q       <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                S_DIV: begin
                    if (bus.cancel) begin
                        state <= S_IDLE;
                    end else begin
                        rem_q <= q_bit ? diff : shifted[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], q_bit};
                        if (count == '0) state <= S_FIX;
                        else             count <= count - 1'b1;
                    end
                end
                default: begin
                    if (bus.cancel) begin
                        state <= S_IDLE;
                    end else begin
                        if (zero_div_q) begin
                            hi_q <= a_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_pipelined_muldiv_unit.sv
// Self-checking bench for pipelined_muldiv_unit against an arithmetic reference model.
// Honours MULDIV_EARLY_OUT_EN for expected divide latency.
module tb_pipelined_muldiv_unit;
    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                           MTHI = 3'd4, MTLO  = 3'd5;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    pipelined_muldiv_unit_if #(.XLEN(XLEN)) bus ();

    pipelined_muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the arithmetic definition of each op.
    task automatic model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        case (o)
            MULT: begin
                sp = longint'($signed(av)) * longint'($signed(bv));
                ref_hi = sp[63:32]; ref_lo = sp[31:0];
            end
            MULTU: begin
                up = {32'd0, av} * {32'd0, bv};
                ref_hi = up[63:32]; ref_lo = up[31:0];
            end
            DIV, DIVU: begin
                if (bv == 0) begin
                    ref_hi = av; ref_lo = 32'hFFFF_FFFF;
                end else if (o == DIVU) begin
                    ref_hi = av % bv; ref_lo = av / bv;
                end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                    ref_hi = 0; ref_lo = av;
                end else begin
                    sa = av; sb = bv;
                    ref_hi = sa % sb; ref_lo = sa / sb;
                end
            end
            MTHI: ref_hi = av;
            MTLO: ref_lo = av;
            default: ;
        endcase
    endtask

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] ma, mb;
        if (o == MULT || o == MULTU) return MUL_STAGES;
        ma = (o == DIV && av[31]) ? -av : av;
        mb = (o == DIV && bv[31]) ? -bv : bv;
`ifdef MULDIV_EARLY_OUT_EN
        if (bv != 0 && ma < mb) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Issues one op and follows it to completion; inject>0 pulses a MULT start while busy.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                                 input int inject);
        int lat, busy_cnt, done_cnt, cyc;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
        model(o, av, bv);
        @(negedge clk);
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        if (o > DIVU) begin
            check("mt_busy", bus.busy, 0);
            check("mt_done", bus.done, 0);
            checkOutput("mt");
            return;
        end
        lat = exp_latency(o, av, bv);
        busy_cnt = 0; done_cnt = 0; cyc = 0;
        while (bus.busy === 1'b1 && cyc < 200) begin
            busy_cnt++;
            if (bus.done === 1'b1) done_cnt++;
            if (inject > 0 && cyc == inject) begin
                bus.start = 1'b1; bus.op = MULT; bus.a = 32'h7; bus.b = 32'h9;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check("busy_len", busy_cnt, lat);
        check("done_early", done_cnt, 0);
        check("done_pulse", bus.done, 1);
        checkOutput("result");
        @(negedge clk);
        check("done_clear", bus.done, 0);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_hi"}, bus.hi, ref_hi);
        check({tag, "_lo"}, bus.lo, ref_lo);
    endtask

    // Starts DIVU 100/7, then aborts it after ten cycles with cancel or clr.
    task automatic abortTest(input bit use_clr);
        int dones;
        applyStimulus(MTHI, 32'd1, 32'd0, 0);
        applyStimulus(MTLO, 32'd2, 32'd0, 0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_busy_before", bus.busy, 1);
        if (use_clr) clr = 1'b1; else bus.cancel = 1'b1;
        @(negedge clk);
        clr = 1'b0; bus.cancel = 1'b0;
        if (use_clr) begin ref_hi = 0; ref_lo = 0; end
        check("abort_busy_after", bus.busy, 0);
        checkOutput(use_clr ? "clr" : "cancel");
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
            @(negedge clk);
        end
        check("abort_no_done", dones, 0);
        checkOutput("abort_hold");
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] av, bv;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi", bus.hi, 0);
        check("reset_lo", bus.lo, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        clr = 1'b0;

        applyStimulus(MULT, 32'hFFFF_FFFD, 32'd5, 0);
        check("mult_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        applyStimulus(MULTU, 32'hFFFF_FFFD, 32'd5, 0);
        check("multu_const", {bus.hi, bus.lo}, 64'h0000_0004_FFFF_FFF1);
        applyStimulus(DIVU, 32'd100, 32'd7, 0);
        check("divu_const", {bus.hi, bus.lo}, {32'd2, 32'd14});
        applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2, 0);
        applyStimulus(DIVU, 32'h1234, 32'd0, 0);
        applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        applyStimulus(DIV, 32'hFFFF_FFF0, 32'd0, 0);

        @(negedge clk);
        bus.start = 1'b1; bus.op = MTHI; bus.a = 32'hA5A5_A5A5;
        @(negedge clk);
        check("mthi_pair", bus.hi, 32'hA5A5_A5A5);
        check("mthi_busy", bus.busy, 0);
        bus.op = MTLO; bus.a = 32'h5A5A_5A5A;
        @(negedge clk);
        bus.start = 1'b0;
        ref_hi = 32'hA5A5_A5A5; ref_lo = 32'h5A5A_5A5A;
        check("mtlo_busy", bus.busy, 0);
        check("mtlo_done", bus.done, 0);
        checkOutput("mt_pair");

        applyStimulus(DIV, 32'd100, 32'd7, 5);
        abortTest(1'b0);
        abortTest(1'b1);
        applyStimulus(DIVU, 32'd3, 32'd10, 0);
        applyStimulus(DIV, 32'hFFFF_FFFD, 32'd10, 0);

        for (int i = 0; i < 30; i++) begin
            o  = 3'($urandom_range(0, 7));
            av = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            case ($urandom_range(0, 5))
                0:       bv = 32'd0;
                1, 2:    bv = 32'($urandom_range(1, 50));
                default: bv = $urandom;
            endcase
            applyStimulus(o, av, bv, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
